// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable, pausable down-counter with a registered one-cycle
//   terminal-count strobe and optional auto-reload.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     load       in   capture load_val into reload register and count, go IDLE
//     load_val   in   WIDTH value captured by load
//     start      in   begin counting from IDLE, restart from DONE
//     pause      in   level; freezes counting while high in RUN
//     reload_en  in   level; reload count at zero instead of stopping
//     count      out  WIDTH current count (registered)
//     busy       out  high in RUN or HOLD
//     tc         out  registered one-cycle terminal-count strobe
//     done       out  high in DONE
//
//   Edge priority: load > start > pause.
module countdown_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             reload_en,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q,     tc_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (load) begin
         // Aborts anything in progress, whatever the state.
         reload_d = load_val;
         count_d  = load_val;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (count_q != '0) begin
                     state_d = RUN;
                  end else begin
                     state_d = DONE;
                     tc_d    = 1'b1;
                  end
               end
            end

            RUN: begin
               if (pause) begin
                  state_d = HOLD;
               end else if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
                  tc_d    = (count_q == WIDTH'(1));
               end else if (reload_en && (reload_q != '0)) begin
                  count_d = reload_q;
               end else begin
                  state_d = DONE;
               end
            end

            HOLD: begin
               if (!pause) begin
                  state_d = RUN;
               end
            end

            DONE: begin
               if (start) begin
                  if (reload_q != '0) begin
                     count_d = reload_q;
                     state_d = RUN;
                  end else begin
                     // A held start with a zero reload value must not keep
                     // tc high on back-to-back cycles.
                     tc_d = ~tc_q;
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign busy  = (state_q == RUN) || (state_q == HOLD);
   assign done  = (state_q == DONE);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, pausable down-counter with terminal-count pulse and optional auto-reload. It is the decrementing counterpart to the free-running `counter` incrementer. It sits beside `ALU` and consumes a programmed value instead of producing a count. It measures programmed intervals and raises a one-cycle `tc` strobe when the count reaches zero.

## Interface
- `WIDTH`, 8: width of `count`, `load_val` and the internal reload register.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately, independent of `clk`.
- `load`  in  1  capture `load_val` into both the reload register and `count`.
- `load_val`  in  WIDTH  value captured by `load`.
- `start`  in  1  begin counting from IDLE, or restart from DONE.
- `pause`  in  1  level; freezes counting while high in RUN.
- `reload_en`  in  1  level; when high, `count` reloads at zero instead of stopping.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high in RUN or HOLD.
- `tc`  out  1  registered one-cycle terminal-count strobe.
- `done`  out  1  high in DONE.

## Operation
- **States:** IDLE, RUN, HOLD, DONE.
- **Reset:** state IDLE; `count`=0; reload register=0; `busy`=0, `tc`=0, `done`=0.
- **Priority at each edge:** `load` > `start` > `pause`.
- **load (any state):** reload register and `count` ← `load_val`; state → IDLE; `tc` ← 0. Any count in progress is aborted.
- **IDLE + start:**
  - `count`≠0 → RUN.
  - `count`=0 → DONE, with `tc` ← 1 on the same edge.
- **RUN:**
  - `pause`=1 → HOLD; `count` is unchanged on that edge.
  - `count`>0 → `count` ← `count`−1. `tc` ← 1 exactly on the edge where `count` goes 1→0, else 0.
  - `count`=0 with `reload_en`=1 and reload register≠0 → `count` ← reload register; stay in RUN.
  - `count`=0 otherwise → DONE.
  - `start` is ignored.
- **HOLD:** `count` is frozen and `tc`=0. `pause`=0 → RUN. `start` is ignored.
- **DONE + start:**
  - Reload register≠0 → `count` ← reload register; state → RUN.
  - Reload register=0 → stay in DONE, with a single `tc` pulse.
- **Arithmetic:** unsigned, WIDTH bits. Decrement never occurs at 0, so there is no wrap to all-ones.
- **tc guarantee:** `tc` never stays high for two consecutive cycles.

## Timing
- `start` sampled at edge E0 with `count`=N>0:
  - RUN from E0.
  - `count`=N−k after edge Ek.
  - `count`=0 and `tc`=1 after edge EN.
  - After EN+1: DONE, `done`=1, `busy`=0. With reload active, `count`=N instead.
- Auto-reload period is N+1 cycles. `tc` repeats every N+1 cycles.
- Each HOLD cycle extends the sequence by one cycle. Pausing at `count`=0 does not repeat `tc`.
- `load` latency is 1 edge; `busy`/`done` clear on the same edge.
- `reset` asserted mid-RUN clears all outputs without waiting for a clock edge. After release, the block stays in IDLE until `load`/`start`.

## Test plan
- **Basic count:** reset, `load_val`=3 with `load`, then `start` → `count` 3,2,1,0 on successive cycles. `tc`=1 only while `count`=0. Next cycle `done`=1, `busy`=0.
- **Auto-reload:** `reload_en`=1, load 2, start → `count` 2,1,0,2,1,0,… `tc` pulses every 3 cycles for at least 4 periods. `done` stays 0.
- **Pause:** load 5, start, assert `pause` when `count`=3 for 4 cycles → `count` holds 3, `busy`=1, `tc`=0. After release, `count` continues 2,1,0 and `tc` fires once.
- **Load abort and simultaneous events:** load 6, start; at `count`=4 assert `load`=1 (`load_val`=9) together with `start`=1 → state IDLE, `count`=9, `busy`=0. `start` is ignored that cycle.
- **Zero and width boundaries:**
  - Load 0, start → single `tc` pulse, DONE, `count` stays 0.
  - Load 8'hFF with `WIDTH`=8 → `tc` arrives exactly 255 cycles after `start`, with no wrap.
- **Async reset mid-run:** load 10, start; drop `reset` between clock edges at `count`=7 → `count`=0, `busy`=0, `done`=0, `tc`=0 immediately. The block stays in IDLE after release.
